// File: rtl/skintone_pkg.sv
// Shared constants for the skin-tone classifier: register map, mode encoding
// and power-on configuration (Q16.16 values for the 32/16 datapath).
package skintone_pkg;

   localparam logic [3:0] ADDR_CX     = 4'd0;
   localparam logic [3:0] ADDR_CY     = 4'd1;
   localparam logic [3:0] ADDR_COS    = 4'd2;
   localparam logic [3:0] ADDR_SIN    = 4'd3;
   localparam logic [3:0] ADDR_ECX    = 4'd4;
   localparam logic [3:0] ADDR_ECY    = 4'd5;
   localparam logic [3:0] ADDR_A2_INV = 4'd6;
   localparam logic [3:0] ADDR_B2_INV = 4'd7;
   localparam logic [3:0] ADDR_RADIUS = 4'd8;
   localparam logic [3:0] ADDR_FAC    = 4'd9;
   localparam logic [3:0] ADDR_Y_MIN  = 4'd10;
   localparam logic [3:0] ADDR_Y_MAX  = 4'd11;
   localparam logic [3:0] ADDR_MODE   = 4'd12;

   typedef enum logic {
      MODE_SCORE = 1'b0,
      MODE_MASK  = 1'b1
   } mode_e;

   localparam logic [31:0] DEF_CX     = 32'h0080_0000;  // 128.0
   localparam logic [31:0] DEF_CY     = 32'h0080_0000;  // 128.0
   localparam logic [31:0] DEF_COS    = 32'h0001_0000;  // 1.0
   localparam logic [31:0] DEF_SIN    = 32'h0000_0000;
   localparam logic [31:0] DEF_ECX    = 32'h0000_0000;
   localparam logic [31:0] DEF_ECY    = 32'h0000_0000;
   localparam logic [31:0] DEF_A2_INV = 32'h0000_0100;  // 1/256
   localparam logic [31:0] DEF_B2_INV = 32'h0000_0100;  // 1/256
   localparam logic [31:0] DEF_RADIUS = 32'h0001_0000;  // 1.0
   localparam logic [31:0] DEF_FAC    = 32'h00FF_0000;  // 255.0
   localparam logic [7:0]  DEF_Y_MIN  = 8'd0;
   localparam logic [7:0]  DEF_Y_MAX  = 8'd255;
   localparam mode_e       DEF_MODE   = MODE_SCORE;

endpackage

// File: rtl/skintone_if.sv
// Pixel-in / result-out stream bundle for skintone_pipe; all lanes share one
// valid/ready pair.
interface skintone_if #(
   parameter int unsigned LANES = 1
);

   logic [24*LANES-1:0] pixel_datain;
   logic                pixel_datain_valid;
   logic                pixel_datain_ready;
   logic [8*LANES-1:0]  result_dataout;
   logic                result_dataout_valid;
   logic                result_dataout_ready;

   modport master (
      output pixel_datain, pixel_datain_valid, result_dataout_ready,
      input  pixel_datain_ready, result_dataout, result_dataout_valid
   );

   modport slave (
      input  pixel_datain, pixel_datain_valid, result_dataout_ready,
      output pixel_datain_ready, result_dataout, result_dataout_valid
   );

endinterface

// File: rtl/fp_mult_sat.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC,
// saturate to the WIDTH-bit signed range. Purely combinational.
module fp_mult_sat
   import skintone_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned FRAC  = 16
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p
);

   localparam logic signed [WIDTH-1:0] P_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] P_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] full;
   logic signed [2*WIDTH-1:0] shifted;

   always_comb begin
      full    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      shifted = full >>> FRAC;
      // In range only when every bit above the result's sign bit matches it.
      if ((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]))
         p = shifted[WIDTH-1:0];
      else
         p = shifted[2*WIDTH-1] ? P_MIN : P_MAX;
   end

endmodule

// File: rtl/skintone_pipe.sv
// Nine-stage, back-pressured YCbCr skin classifier: rotated-ellipse distance in
// the Cb/Cr plane plus a luma gate, giving a per-lane score or mask byte.
module skintone_pipe
   import skintone_pkg::*;
#(
   parameter int unsigned FP_WIDTH  = 32,
   parameter int unsigned FRAC_BITS = 16,
   parameter int unsigned LANES     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   skintone_if.slave           pif,
   input  logic                cfg_we,
   input  logic [3:0]          cfg_addr,
   input  logic [FP_WIDTH-1:0] cfg_wdata,
   output logic                cfg_ready
);

   typedef logic signed [FP_WIDTH-1:0] fp_t;

   localparam fp_t FP_MAX = {1'b0, {(FP_WIDTH-1){1'b1}}};
   localparam fp_t FP_MIN = {1'b1, {(FP_WIDTH-1){1'b0}}};

   function automatic fp_t sat_add(input fp_t a, input fp_t b);
      logic signed [FP_WIDTH:0] s;
      s = {a[FP_WIDTH-1], a} + {b[FP_WIDTH-1], b};
      if (s[FP_WIDTH] != s[FP_WIDTH-1]) return s[FP_WIDTH] ? FP_MIN : FP_MAX;
      return s[FP_WIDTH-1:0];
   endfunction

   function automatic fp_t sat_sub(input fp_t a, input fp_t b);
      logic signed [FP_WIDTH:0] s;
      s = {a[FP_WIDTH-1], a} - {b[FP_WIDTH-1], b};
      if (s[FP_WIDTH] != s[FP_WIDTH-1]) return s[FP_WIDTH] ? FP_MIN : FP_MAX;
      return s[FP_WIDTH-1:0];
   endfunction

   fp_t        r_cx, r_cy, r_cos, r_sin, r_ecx, r_ecy, r_a2, r_b2, r_rad, r_fac;
   logic [7:0] r_ymin, r_ymax;
   mode_e      r_mode;

   fp_t        c_cx, c_cy, c_cos, c_sin, c_ecx, c_ecy, c_a2, c_b2, c_rad, c_fac;
   logic [7:0] c_ymin, c_ymax;
   mode_e      c_mode;
   fp_t        c_nsin;

   logic [8:0] vld;
   logic       adv;
   logic       cfg_commit;

   assign adv                      = !vld[8] || pif.result_dataout_ready;
   assign pif.pixel_datain_ready   = adv;
   assign pif.result_dataout_valid = vld[8];
   assign cfg_ready                = ~|vld;
   assign cfg_commit               = cfg_we && cfg_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cx   <= fp_t'(DEF_CX);
         r_cy   <= fp_t'(DEF_CY);
         r_cos  <= fp_t'(DEF_COS);
         r_sin  <= fp_t'(DEF_SIN);
         r_ecx  <= fp_t'(DEF_ECX);
         r_ecy  <= fp_t'(DEF_ECY);
         r_a2   <= fp_t'(DEF_A2_INV);
         r_b2   <= fp_t'(DEF_B2_INV);
         r_rad  <= fp_t'(DEF_RADIUS);
         r_fac  <= fp_t'(DEF_FAC);
         r_ymin <= DEF_Y_MIN;
         r_ymax <= DEF_Y_MAX;
         r_mode <= DEF_MODE;
      end else if (cfg_commit) begin
         case (cfg_addr)
            ADDR_CX:     r_cx   <= cfg_wdata;
            ADDR_CY:     r_cy   <= cfg_wdata;
            ADDR_COS:    r_cos  <= cfg_wdata;
            ADDR_SIN:    r_sin  <= cfg_wdata;
            ADDR_ECX:    r_ecx  <= cfg_wdata;
            ADDR_ECY:    r_ecy  <= cfg_wdata;
            ADDR_A2_INV: r_a2   <= cfg_wdata;
            ADDR_B2_INV: r_b2   <= cfg_wdata;
            ADDR_RADIUS: r_rad  <= cfg_wdata;
            ADDR_FAC:    r_fac  <= cfg_wdata;
            ADDR_Y_MIN:  r_ymin <= cfg_wdata[7:0];
            ADDR_Y_MAX:  r_ymax <= cfg_wdata[7:0];
            ADDR_MODE:   r_mode <= mode_e'(cfg_wdata[0]);
            default:     ;
         endcase
      end
   end

   // A committing write is forwarded so a beat accepted on the same edge sees
   // the new value; commits only happen with an empty pipe, so no beat in
   // flight can observe a change.
   always_comb begin
      c_cx   = r_cx;
      c_cy   = r_cy;
      c_cos  = r_cos;
      c_sin  = r_sin;
      c_ecx  = r_ecx;
      c_ecy  = r_ecy;
      c_a2   = r_a2;
      c_b2   = r_b2;
      c_rad  = r_rad;
      c_fac  = r_fac;
      c_ymin = r_ymin;
      c_ymax = r_ymax;
      c_mode = r_mode;
      if (cfg_commit) begin
         case (cfg_addr)
            ADDR_CX:     c_cx   = cfg_wdata;
            ADDR_CY:     c_cy   = cfg_wdata;
            ADDR_COS:    c_cos  = cfg_wdata;
            ADDR_SIN:    c_sin  = cfg_wdata;
            ADDR_ECX:    c_ecx  = cfg_wdata;
            ADDR_ECY:    c_ecy  = cfg_wdata;
            ADDR_A2_INV: c_a2   = cfg_wdata;
            ADDR_B2_INV: c_b2   = cfg_wdata;
            ADDR_RADIUS: c_rad  = cfg_wdata;
            ADDR_FAC:    c_fac  = cfg_wdata;
            ADDR_Y_MIN:  c_ymin = cfg_wdata[7:0];
            ADDR_Y_MAX:  c_ymax = cfg_wdata[7:0];
            ADDR_MODE:   c_mode = mode_e'(cfg_wdata[0]);
            default:     ;
         endcase
      end
   end

   assign c_nsin = sat_sub('0, c_sin);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   vld <= '0;
      else if (adv) vld <= {vld[7:0], pif.pixel_datain_valid};
   end

   logic [8*LANES-1:0] res_bus;
   assign pif.result_dataout = res_bus;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [7:0] y_in, cb_in, cr_in;
      fp_t        cb_fp, cr_fp;
      logic       gate_in;

      fp_t        s1_dx, s1_dy;
      fp_t        p_cdx, p_sdy, p_nsdx, p_cdy;
      fp_t        s2_cdx, s2_sdy, s2_nsdx, s2_cdy;
      fp_t        s3_x, s3_y;
      fp_t        s4_u, s4_v;
      fp_t        p_uu, p_vv, s5_uu, s5_vv;
      fp_t        p_a, p_b, s6_a, s6_b;
      fp_t        s7_d;
      logic       s8_in;
      fp_t        s8_diff;
      fp_t        p_fd, fd_int;
      logic [7:0] score, res_next, s9_res;
      logic [7:0] yg;  // luma-gate result riding alongside S1..S8

      assign y_in    = pif.pixel_datain[24*g+16 +: 8];
      assign cb_in   = pif.pixel_datain[24*g+8  +: 8];
      assign cr_in   = pif.pixel_datain[24*g    +: 8];
      assign cb_fp   = fp_t'(cb_in) << FRAC_BITS;
      assign cr_fp   = fp_t'(cr_in) << FRAC_BITS;
      assign gate_in = (y_in >= c_ymin) && (y_in <= c_ymax);

      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_cdx  (.a(c_cos),  .b(s1_dx),   .p(p_cdx));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_sdy  (.a(c_sin),  .b(s1_dy),   .p(p_sdy));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_nsdx (.a(c_nsin), .b(s1_dx),   .p(p_nsdx));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_cdy  (.a(c_cos),  .b(s1_dy),   .p(p_cdy));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_uu   (.a(s4_u),   .b(s4_u),    .p(p_uu));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_vv   (.a(s4_v),   .b(s4_v),    .p(p_vv));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_a    (.a(c_a2),   .b(s5_uu),   .p(p_a));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_b    (.a(c_b2),   .b(s5_vv),   .p(p_b));
      fp_mult_sat #(.WIDTH(FP_WIDTH), .FRAC(FRAC_BITS)) u_fd   (.a(c_fac),  .b(s8_diff), .p(p_fd));

      assign fd_int = p_fd >>> FRAC_BITS;

      always_comb begin
         if (fd_int[FP_WIDTH-1])        score = 8'h00;
         else if (fd_int > fp_t'(255))  score = 8'hFF;
         else                           score = fd_int[7:0];
         res_next = 8'h00;
         if (s8_in && yg[7]) res_next = (c_mode == MODE_MASK) ? 8'hFF : score;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_dx   <= '0;
            s1_dy   <= '0;
            s2_cdx  <= '0;
            s2_sdy  <= '0;
            s2_nsdx <= '0;
            s2_cdy  <= '0;
            s3_x    <= '0;
            s3_y    <= '0;
            s4_u    <= '0;
            s4_v    <= '0;
            s5_uu   <= '0;
            s5_vv   <= '0;
            s6_a    <= '0;
            s6_b    <= '0;
            s7_d    <= '0;
            s8_in   <= 1'b0;
            s8_diff <= '0;
            s9_res  <= '0;
            yg      <= '0;
         end else if (adv) begin
            s1_dx   <= sat_sub(cb_fp, c_cx);
            s1_dy   <= sat_sub(c_cy, cr_fp);
            s2_cdx  <= p_cdx;
            s2_sdy  <= p_sdy;
            s2_nsdx <= p_nsdx;
            s2_cdy  <= p_cdy;
            s3_x    <= sat_add(s2_cdx, s2_sdy);
            s3_y    <= sat_add(s2_nsdx, s2_cdy);
            s4_u    <= sat_sub(s3_x, c_ecx);
            s4_v    <= sat_sub(s3_y, c_ecy);
            s5_uu   <= p_uu;
            s5_vv   <= p_vv;
            s6_a    <= p_a;
            s6_b    <= p_b;
            s7_d    <= sat_add(s6_a, s6_b);
            s8_in   <= (s7_d <= c_rad);
            s8_diff <= sat_sub(c_rad, s7_d);
            s9_res  <= res_next;
            yg      <= {yg[6:0], gate_in};
         end
      end

      assign res_bus[8*g +: 8] = s9_res;
   end

endmodule
